// File: rtl/ones_cnt_sched_pkg.sv
// rtl/ones_cnt_sched_pkg.sv - shared types and defaults for the ones-count scheduler
package ones_cnt_pkg;

    localparam int S_IDLE_IDX = 0;
    localparam int S_1_IDX    = 1;
    localparam int S_2_IDX    = 2;
    localparam int S_3_IDX    = 3;

    localparam int DEF_W     = 8;
    localparam int DEF_N_REQ = 4;

    // One-hot controller state: idle / zero-check / shift / E-check
    typedef enum logic [3:0] {
        S_IDLE = 4'(1 << S_IDLE_IDX),
        S_1    = 4'(1 << S_1_IDX),
        S_2    = 4'(1 << S_2_IDX),
        S_3    = 4'(1 << S_3_IDX)
    } state_t;

endpackage

// File: rtl/ones_cnt_sched_if.sv
// rtl/ones_cnt_sched_if.sv - requester-side bundle of the ones-count scheduler
interface ones_cnt_sched_if #(
    parameter int N_REQ = 4,
    parameter int W     = 8
) ();
    localparam int CW = $clog2(W + 1);

    logic [N_REQ-1:0]   req;
    logic [N_REQ*W-1:0] data_in;
    logic               rdy;
    logic [N_REQ-1:0]   gnt;
    logic [N_REQ-1:0]   done;
    logic [CW-1:0]      count_out;

    modport master (
        output req, data_in,
        input  rdy, gnt, done, count_out
    );

    modport slave (
        input  req, data_in,
        output rdy, gnt, done, count_out
    );
endinterface

// File: rtl/ones_cnt_sched_rr_arbiter.sv
// rtl/ones_cnt_sched_rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic             any_req,
    output logic [IW-1:0]    gnt_idx
);

    assign any_req = |req;

    // Scan from ptr upward with wrap; the first hit wins
    always_comb begin
        logic found;
        int   idx;
        found   = 1'b0;
        idx     = 0;
        gnt_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && req[idx]) begin
                gnt_idx = IW'(idx);
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ones_cnt_sched.sv
// rtl/ones_cnt_sched.sv - shared shift/count popcount unit with round-robin requester access
module ones_cnt_sched
    import ones_cnt_pkg::*;
#(
    parameter  int N_REQ = DEF_N_REQ,
    parameter  int W     = DEF_W,
    localparam int CW    = $clog2(W + 1),
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic            clk,
    input  logic            rst_b,
    ones_cnt_sched_if.slave bus
);

    state_t        state;
    logic [W-1:0]  r1;
    logic [CW-1:0] r2;
    logic          e;
    logic [IW-1:0] owner;
    logic [IW-1:0] ptr;

    logic          any_req;
    logic [IW-1:0] g_idx;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req     (bus.req),
        .ptr     (ptr),
        .any_req (any_req),
        .gnt_idx (g_idx)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= S_IDLE;
            r1    <= '0;
            r2    <= '0;
            e     <= 1'b0;
            owner <= '0;
            ptr   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        r1    <= bus.data_in[g_idx*W +: W];
                        r2    <= '0;
                        e     <= 1'b0;
                        owner <= g_idx;
                        ptr   <= (g_idx == IW'(N_REQ - 1)) ? '0 : g_idx + IW'(1);
                        state <= S_1;
                    end
                end
                S_1: state <= (r1 == '0) ? S_IDLE : S_2;
                S_2: begin
                    {e, r1} <= {r1, 1'b0};
                    state   <= S_3;
                end
                S_3: begin
                    if (e) begin
                        r2    <= r2 + CW'(1);
                        state <= S_1;
                    end else begin
                        state <= S_2;
                    end
                end
                // Any non-one-hot encoding falls back to idle
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.rdy       = (state == S_IDLE);
    assign bus.count_out = r2;

    always_comb begin
        bus.gnt  = '0;
        bus.done = '0;
        if (state == S_1 || state == S_2 || state == S_3)
            bus.gnt[owner] = 1'b1;
        if (state == S_1 && r1 == '0)
            bus.done[owner] = 1'b1;
    end

endmodule

// File: tb/tb_ones_cnt_sched.sv
// tb/tb_ones_cnt_sched.sv - self-checking bench for ones_cnt_sched
module tb_ones_cnt_sched;
    localparam int N = 4;
    localparam int W = 8;

    logic clk   = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    ones_cnt_sched_if #(.N_REQ(N), .W(W)) bus ();

    ones_cnt_sched #(.N_REQ(N), .W(W)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] one(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Cycles from grant edge to end of done cycle, from the bit pattern itself
    function automatic int ref_lat(input logic [W-1:0] x);
        int low;
        if (x == 0) return 1;
        low = 0;
        while (x[low] == 1'b0) low++;
        return 1 + 2 * (W - low) + $countones(x);
    endfunction

    task automatic set_req(input int i, input logic v, input logic [W-1:0] d);
        bus.data_in[i*W +: W] = d;
        bus.req[i]            = v;
    endtask

    task automatic serve_one(input int idx, input logic [W-1:0] d, input int cnt,
                             input int lat, input bit drop_mid);
        bit seen;
        bit gnt_ok;
        int n;
        seen   = 0;
        gnt_ok = 1;
        @(negedge clk);
        set_req(idx, 1'b1, d);
        for (n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (bus.gnt !== one(idx)) gnt_ok = 0;
            if (drop_mid && n == 3) bus.req[idx] = 1'b0;
            if (bus.done !== '0) begin
                seen = 1;
                break;
            end
        end
        chk("done_seen", 32'(seen), 1);
        if (seen) begin
            chk("latency", n, lat);
            chk("done_bits", 32'(bus.done), 32'(one(idx)));
            chk("count", 32'(bus.count_out), cnt);
        end
        chk("gnt_held", 32'(gnt_ok), 1);
        bus.req[idx] = 1'b0;
        @(negedge clk);
        chk("rdy_after", 32'(bus.rdy), 1);
        chk("gnt_after", 32'(bus.gnt), 0);
    endtask

    typedef struct {
        int           idx;
        logic [W-1:0] data;
        int           cnt;
        int           lat;
        bit           drop;
    } vec_t;

    vec_t vecs[8];

    // Random-phase reference state
    logic [N-1:0] req_applied;
    logic [W-1:0] mdata[N];
    bit           mbusy;
    int           mown, mptr, mlat, mel, mcnt;

    initial begin
        int order[4];
        int ocnt[4];
        int olat[4];
        int served, gap, pending;
        logic [N-1:0] exp_gnt, exp_done;

        bus.req     = '0;
        bus.data_in = '0;
        rst_b       = 1'b0;
        repeat (2) @(negedge clk);
        rst_b = 1'b1;

        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("reset_rdy", 32'(bus.rdy), 1);
            chk("reset_gnt", 32'(bus.gnt), 0);
            chk("reset_done", 32'(bus.done), 0);
            chk("reset_count", 32'(bus.count_out), 0);
        end

        vecs[0] = '{0, 8'h00, 0, 1,  0};
        vecs[1] = '{1, 8'hB4, 4, 17, 0};
        vecs[2] = '{3, 8'h80, 1, 4,  0};
        vecs[3] = '{2, 8'h81, 2, 19, 1};
        vecs[4] = '{1, 8'h0F, 4, 21, 0};
        vecs[5] = '{0, 8'hF0, 4, 13, 0};
        vecs[6] = '{3, 8'hFF, 8, 25, 0};
        vecs[7] = '{2, 8'h01, 1, 18, 0};
        for (int v = 0; v < 8; v++)
            serve_one(vecs[v].idx, vecs[v].data, vecs[v].cnt, vecs[v].lat, vecs[v].drop);

        // Reset pulse while a 0x01 operation is in its shift state
        @(negedge clk);
        set_req(1, 1'b1, 8'h01);
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        chk("midrst_rdy", 32'(bus.rdy), 1);
        chk("midrst_gnt", 32'(bus.gnt), 0);
        chk("midrst_done", 32'(bus.done), 0);
        chk("midrst_count", 32'(bus.count_out), 0);
        @(negedge clk);
        chk("midrst_done_hold", 32'(bus.done), 0);
        bus.req[1] = 1'b0;
        rst_b      = 1'b1;
        @(negedge clk);
        chk("midrst_no_done", 32'(bus.done), 0);

        // Three requesters held together; pointer starts at 0 after the reset
        order = '{0, 2, 3, 0};
        ocnt  = '{8, 2, 1, 8};
        olat  = '{25, 19, 4, 25};
        set_req(0, 1'b1, 8'hFF);
        set_req(2, 1'b1, 8'h03);
        set_req(3, 1'b1, 8'h80);
        served  = 0;
        gap     = 0;
        pending = -1;
        for (int c = 0; c < 400 && served < 4; c++) begin
            @(negedge clk);
            gap++;
            if (bus.done !== '0) begin
                chk("rr_done", 32'(bus.done), 32'(one(order[served])));
                chk("rr_count", 32'(bus.count_out), ocnt[served]);
                chk("rr_latency", gap - (served == 0 ? 0 : 1), olat[served]);
                bus.req[order[served]] = 1'b0;
                pending = order[served];
                served++;
                gap = 0;
            end else if (pending >= 0) begin
                bus.req[pending] = 1'b1;
                pending = -1;
            end
        end
        chk("rr_served", served, 4);
        bus.req = '0;

        // Randomized traffic against the reference scheduler
        @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);
        rst_b       = 1'b1;
        req_applied = '0;
        mbusy       = 0;
        mptr        = 0;
        mown        = 0;
        mlat        = 0;
        mel         = 0;
        mcnt        = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (mbusy) begin
                if (mel == mlat) mbusy = 0;
                else mel++;
            end else if (req_applied != '0) begin
                for (int k = 0; k < N; k++) begin
                    if (!mbusy && req_applied[(mptr + k) % N]) begin
                        mown  = (mptr + k) % N;
                        mbusy = 1;
                    end
                end
                mptr = (mown + 1) % N;
                mlat = ref_lat(mdata[mown]);
                mcnt = $countones(mdata[mown]);
                mel  = 1;
            end
            exp_gnt  = mbusy ? one(mown) : '0;
            exp_done = (mbusy && mel == mlat) ? one(mown) : '0;
            chk("rnd_rdy", 32'(bus.rdy), 32'(!mbusy));
            chk("rnd_gnt", 32'(bus.gnt), 32'(exp_gnt));
            chk("rnd_done", 32'(bus.done), 32'(exp_done));
            if (exp_done != '0) chk("rnd_count", 32'(bus.count_out), mcnt);

            for (int i = 0; i < N; i++) begin
                if (exp_done[i]) begin
                    bus.req[i] = 1'b0;
                end else if (!bus.req[i] && $urandom_range(0, 3) == 0) begin
                    case ($urandom_range(0, 5))
                        0:       mdata[i] = 8'h00;
                        1:       mdata[i] = 8'hFF;
                        default: mdata[i] = 8'($urandom);
                    endcase
                    set_req(i, 1'b1, mdata[i]);
                end
            end
            req_applied = bus.req;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
